// File: rtl/reg_seq.sv
`default_nettype none
// reg_seq: IDLE/EXEC/WB micro-op sequencer that drives an 8x16 register file.
// Zero/carry flags are built only when REG_SEQ_FLAGS_EN is defined.
module reg_seq #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  input  logic [DW-1:0] imm,
  output logic [AW-1:0] rf_rd_addr_a,
  output logic [AW-1:0] rf_rd_addr_b,
  input  logic [DW-1:0] rf_d_out_a,
  input  logic [DW-1:0] rf_d_out_b,
  output logic          rf_wr,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_d_in,
`ifdef REG_SEQ_FLAGS_EN
  output logic          flag_z,
  output logic          flag_c,
`endif
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  logic [1:0]    state, state_next;
  logic [2:0]    op_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] result_q;
  logic          done_q;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic [DW:0]   wide;
  logic          accept;
  logic          unused_bits;

  assign unused_bits = ^instr[3:0];
  assign accept      = (state == S_IDLE) && instr_valid;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (instr_valid) state_next = S_EXEC;
      S_EXEC:  state_next = (op_q == OP_NOP) ? S_IDLE : S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are gated by reset so an abort suppresses the write and done pulse immediately.
  always_comb begin
    instr_ready = reset && (state == S_IDLE);
    rf_wr       = reset && (state == S_WB);
    done        = reset && done_q;
    rf_d_in     = result_q;
  end

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_MOV: alu_res = rf_d_out_a;
      OP_ADD: begin
        wide    = {1'b0, rf_d_out_a} + {1'b0, rf_d_out_b};
        alu_res = wide[DW-1:0];
        alu_c   = wide[DW];
      end
      OP_SUB: begin
        wide    = {1'b0, rf_d_out_a} - {1'b0, rf_d_out_b};
        alu_res = wide[DW-1:0];
        alu_c   = wide[DW];
      end
      OP_AND:  alu_res = rf_d_out_a & rf_d_out_b;
      OP_OR:   alu_res = rf_d_out_a | rf_d_out_b;
      OP_XOR:  alu_res = rf_d_out_a ^ rf_d_out_b;
      OP_LDI:  alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q         <= OP_NOP;
      imm_q        <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      rf_rd_addr_a <= '0;
      rf_rd_addr_b <= '0;
      rf_wr_addr   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q         <= instr[15:13];
        rf_wr_addr   <= AW'(instr[12:10]);
        rf_rd_addr_a <= AW'(instr[9:7]);
        rf_rd_addr_b <= AW'(instr[6:4]);
        imm_q        <= imm;
      end
      if (state == S_EXEC) begin
        result_q <= alu_res;
        done_q   <= 1'b1;
      end
    end
  end

`ifdef REG_SEQ_FLAGS_EN
  logic carry_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      carry_q <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      if (state == S_EXEC) carry_q <= alu_c;
      if (state == S_WB) begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            flag_z <= (result_q == '0);
            flag_c <= carry_q;
          end
          OP_AND, OP_OR, OP_XOR: begin
            flag_z <= (result_q == '0);
            flag_c <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_c;
`endif

endmodule
`default_nettype wire
